// File: rtl/btn_debouncer_pkg.sv
// Shared types and helpers for the multi-channel button/sensor debouncer.
// Holds the channel state encoding, timing defaults and a width helper.
package btn_debouncer_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 10;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser chain, STABLE/PENDING qualifier and clean register.
// Outputs are registered; clean follows raw only after STABLE_TICKS counted ticks.
module debounce_channel
  import btn_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic busy
);

  localparam int             TW        = clog2_min1(STABLE_TICKS);
  localparam logic [TW-1:0]  TCNT_LAST = TW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [TW-1:0]          tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // A tick seen in the cycle that detects the change is deliberately not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE;
      tcnt  <= '0;
      clean <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (s != clean) begin
            state <= ST_PENDING;
            busy  <= 1'b1;
            tcnt  <= '0;
          end
        end
        ST_PENDING: begin
          if (s == clean) begin
            state <= ST_STABLE;
            busy  <= 1'b0;
            tcnt  <= '0;
          end else if (tick && (tcnt == TCNT_LAST)) begin
            clean <= s;
            state <= ST_STABLE;
            busy  <= 1'b0;
            tcnt  <= '0;
          end else if (tick) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE;
          busy  <= 1'b0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel debouncer: shared sample-tick prescaler feeding N_CH independent lanes.
// btn_clean/btn_busy are registered; no combinational path from btn_in.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_clean,
  output logic [N_CH-1:0] btn_busy
);

  localparam int            PW      = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_cnt;
  logic          tick;

  // With TICK_DIV=1 the counter sits at 0 == PS_LAST, so tick is held high.
  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .raw  (btn_in[i]),
      .clean(btn_clean[i]),
      .busy (btn_busy[i])
    );
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
- Multi-channel input conditioner for the parking-lot push-buttons and vehicle sensors.
- Synchronises each raw asynchronous input to clk and filters bounce. Produces a clean level that changes only after the input has been stable for a programmable time.
- Sits directly upstream of the edge detector, which turns each clean rising level into a one-cycle event.

Parameters:
- N_CH, 2, number of independent input channels (e.g. entry, exit).
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain; legal values >= 2.
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal values >= 1.
- STABLE_TICKS, 10, consecutive ticks the synchronised input must hold a new level before the clean output follows; legal values >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_CH  raw, asynchronous, bouncing inputs; bit i is channel i.
- btn_clean  out  N_CH  debounced level per channel.
- btn_busy  out  N_CH  1 while channel i is in PENDING, i.e. a candidate level change is being qualified.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops = 0; btn_clean = 0; btn_busy = 0.
  - Prescaler = 0; all channels in STABLE with tick count 0.
  - Everything is released on the first clk edge with rst_n=1.
- Synchroniser: each channel has SYNC_STAGES flops. s[i] is the last stage. No logic is placed between the stages.
- Prescaler:
  - Shared counter, 0..TICK_DIV-1, free-running and wraps to 0.
  - tick = (count == TICK_DIV-1), high for exactly one cycle per period.
  - With TICK_DIV=1, tick is constantly 1.
- Per-channel FSM, two states:
  - STABLE: btn_busy=0. If s != btn_clean, go to PENDING with tcnt=0. Otherwise stay.
  - PENDING, bounce back: btn_busy=1. If s == btn_clean, return to STABLE with tcnt=0 and btn_clean unchanged. This covers any glitch shorter than the qualification window.
  - PENDING, last tick: else if tick and tcnt == STABLE_TICKS-1, set btn_clean <= s and go to STABLE with tcnt=0.
  - PENDING, other tick: else if tick, tcnt <= tcnt+1.
  - PENDING, no tick: hold.
- Tick counting rule: only ticks occurring in cycles where the state is already PENDING are counted. A tick in the cycle that detects the change is not counted.
- Latency:
  - Let E0 be the clk edge that first samples the new btn_in level.
  - The channel enters PENDING on edge E0+SYNC_STAGES.
  - btn_clean updates on the edge where the STABLE_TICKS-th counted tick occurs. That is between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV edges after entering PENDING.
  - With TICK_DIV=1 this is exactly E0+SYNC_STAGES+STABLE_TICKS.
- Width rules:
  - Prescaler width = clog2(TICK_DIV), minimum 1.
  - tcnt width = clog2(STABLE_TICKS), minimum 1.
  - No counter may exceed its terminal value; counters never wrap inside PENDING.
- Channel independence: channels share only the prescaler tick. Simultaneous changes on several channels are qualified independently and may update btn_clean in the same cycle.
- Rising and falling transitions are qualified identically, so filtering is symmetric.
- Reset mid-operation: an asserted rst_n aborts PENDING immediately. btn_clean returns to 0 even if the input is held high. After release, a held-high input re-qualifies from scratch.
- btn_clean and btn_busy are registered outputs with no combinational path from btn_in.

Decomposition:
- Shared package btn_debouncer_pkg:
  - State encoding constants ST_STABLE and ST_PENDING.
  - Defaults for TICK_DIV and STABLE_TICKS.
  - A clog2 helper function.
- One sub-module debounce_channel holds the synchroniser, FSM, tcnt and the clean register for a single bit. It takes tick as an input.
- The top level holds the prescaler and a generate loop instantiating N_CH channels.

Test Plan:
- Clean step, TICK_DIV=1, STABLE_TICKS=3, SYNC_STAGES=2: btn_in[0] goes 0->1 at E0 and is held. btn_busy[0] rises on E2. btn_clean[0] rises on E5 and btn_busy[0] falls on the same edge. Channel 1 stays 0 throughout.
- Bounce rejection, same parameters:
  - btn_in[0] pulses high for 2 cycles then returns low. btn_busy[0] pulses; btn_clean[0] never leaves 0.
  - Then 1-cycle high pulses spaced 2 cycles apart for 20 cycles. btn_clean[0] stays 0.
- Tick-gated timing, TICK_DIV=4, STABLE_TICKS=3: step on btn_in[1] at several prescaler phases (0..3). btn_clean[1] rises 9..12 edges after PENDING entry, each phase matching the formula exactly. A falling step after stable high gives the same delays.
- Simultaneous channels: both bits step 0->1 on the same edge. Both btn_clean bits rise on the same edge. Next, bit 0 bounces while bit 1 falls cleanly. Bit 1 goes low on schedule, unaffected by bit 0.
- Reset mid-operation:
  - Assert rst_n=0 while channel 0 is in PENDING with tcnt=2. btn_clean=0 and btn_busy=0 immediately, without waiting for a clk edge.
  - Release with btn_in held 1. btn_clean[0] rises only after a full SYNC_STAGES+STABLE_TICKS window.
- Regression hook: feed btn_clean[0] into the edge detector and count its pulses. Ten bounced presses (each bouncing 5 times within the window) yield exactly 10 rising_edge pulses.
